// File: rtl/alu_tv_pkg.sv
// rtl/alu_tv_pkg.sv - shared types and field layout for the ALU test-vector checker
package alu_tv_pkg;

  localparam int VEC_W        = 101;
  localparam int DATA_W       = 32;
  localparam int F_W          = 4;
  localparam int EXP_ZERO_LSB = 0;
  localparam int EXP_Y_LSB    = EXP_ZERO_LSB + 1;
  localparam int B_LSB        = EXP_Y_LSB + DATA_W;
  localparam int A_LSB        = B_LSB + DATA_W;
  localparam int F_LSB        = A_LSB + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } tv_state_e;

  typedef struct packed {
    logic [F_W-1:0]    f;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp_y;
    logic              exp_zero;
  } tv_vec_t;

  function automatic tv_vec_t tv_unpack(input logic [VEC_W-1:0] raw);
    tv_vec_t v;
    v.f        = raw[F_LSB +: F_W];
    v.a        = raw[A_LSB +: DATA_W];
    v.b        = raw[B_LSB +: DATA_W];
    v.exp_y    = raw[EXP_Y_LSB +: DATA_W];
    v.exp_zero = raw[EXP_ZERO_LSB];
    return v;
  endfunction

endpackage

// File: rtl/alu_tv_checker_if.sv
// rtl/alu_tv_checker_if.sv - vector memory read port and ALU drive/observe bus
interface alu_tv_checker_if #(
  parameter int ADDR_W = 1
);

  logic                          vec_rd_en;
  logic [ADDR_W-1:0]             vec_addr;
  logic [alu_tv_pkg::VEC_W-1:0]  vec_data;
  logic [31:0]                   alu_a;
  logic [31:0]                   alu_b;
  logic [2:0]                    alu_f;
  logic [31:0]                   alu_y;
  logic                          alu_zero;

  modport master (
    output vec_rd_en, vec_addr, alu_a, alu_b, alu_f,
    input  vec_data, alu_y, alu_zero
  );

  modport slave (
    input  vec_rd_en, vec_addr, alu_a, alu_b, alu_f,
    output vec_data, alu_y, alu_zero
  );

endinterface

// File: rtl/alu_tv_compare.sv
// rtl/alu_tv_compare.sv - flags any difference between ALU results and expected values
module alu_tv_compare (
  input  logic [31:0] alu_y_i,
  input  logic        alu_zero_i,
  input  logic [31:0] exp_y_i,
  input  logic        exp_zero_i,
  output logic        mismatch_o
);

  assign mismatch_o = (alu_y_i != exp_y_i) || (alu_zero_i != exp_zero_i);

endmodule

// File: rtl/alu_tv_checker.sv
// rtl/alu_tv_checker.sv - walks a vector memory through the ALU and tallies pass/fail
module alu_tv_checker
  import alu_tv_pkg::*;
#(
  parameter int NUM_VECTORS   = 30,
  parameter int SETTLE_CYCLES = 1,
  parameter int ADDR_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  parameter int CNT_W         = $clog2(NUM_VECTORS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  alu_tv_checker_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic                first_fail_valid,
  output logic [ADDR_W-1:0]   first_fail_idx
);

  localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VECTORS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  tv_state_e          state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [SET_W-1:0]   settle_q;
  logic [31:0]        alu_a_q;
  logic [31:0]        alu_b_q;
  logic [2:0]         alu_f_q;
  logic [31:0]        exp_y_q;
  logic               exp_zero_q;
  logic [CNT_W-1:0]   pass_q;
  logic [CNT_W-1:0]   fail_q;
  logic               ff_valid_q;
  logic [ADDR_W-1:0]  ff_idx_q;

  tv_vec_t            vec;
  logic               mismatch;
  logic               unused_f3;

  assign vec       = tv_unpack(bus.vec_data);
  // f[3] is a spare opcode bit the ALU never sees
  assign unused_f3 = vec.f[3];

  alu_tv_compare u_compare (
    .alu_y_i    (bus.alu_y),
    .alu_zero_i (bus.alu_zero),
    .exp_y_i    (exp_y_q),
    .exp_zero_i (exp_zero_q),
    .mismatch_o (mismatch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_f_q    <= '0;
      exp_y_q    <= '0;
      exp_zero_q <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            idx_q      <= '0;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          alu_a_q    <= vec.a;
          alu_b_q    <= vec.b;
          alu_f_q    <= vec.f[2:0];
          exp_y_q    <= vec.exp_y;
          exp_zero_q <= vec.exp_zero;
          settle_q   <= SETTLE_LOAD;
          state_q    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            fail_q <= fail_q + CNT_W'(1);
            if (!ff_valid_q) begin
              ff_valid_q <= 1'b1;
              ff_idx_q   <= idx_q;
            end
          end else begin
            pass_q <= pass_q + CNT_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status and memory strobes decode straight from the state register
  assign busy             = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                            (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done             = (state_q == ST_DONE);
  assign bus.vec_rd_en    = (state_q == ST_FETCH);
  assign bus.vec_addr     = idx_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_f        = alu_f_q;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;

endmodule

// File: tb/tb_alu_tv_checker.sv
// tb/tb_alu_tv_checker.sv - scoreboard bench for alu_tv_checker
module tb_alu_tv_checker;
  import alu_tv_pkg::*;

  typedef struct {
    int pass_n;
    int fail_n;
    int ffv;
    int ffidx;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, start_b, start_c;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   prev_c = -1;

  exp_t    sb_q[$];
  int      addr_q_a[$];
  int      addr_q_c[$];
  tv_vec_t mem_a[$];
  tv_vec_t mem_b[$];
  tv_vec_t mem_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  alu_tv_checker_if #(.ADDR_W(2)) ifa ();
  alu_tv_checker_if #(.ADDR_W(1)) ifb ();
  alu_tv_checker_if #(.ADDR_W(2)) ifc ();

  logic       busy_a, done_a, ffv_a;
  logic [2:0] pass_a, fail_a;
  logic [1:0] ffidx_a;
  logic       busy_b, done_b, ffv_b;
  logic [0:0] pass_b, fail_b;
  logic [0:0] ffidx_b;
  logic       busy_c, done_c, ffv_c;
  logic [2:0] pass_c, fail_c;
  logic [1:0] ffidx_c;

  alu_tv_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .pass_count(pass_a), .fail_count(fail_a),
    .first_fail_valid(ffv_a), .first_fail_idx(ffidx_a)
  );

  alu_tv_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .pass_count(pass_b), .fail_count(fail_b),
    .first_fail_valid(ffv_b), .first_fail_idx(ffidx_b)
  );

  alu_tv_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .bus(ifc),
    .busy(busy_c), .done(done_c), .pass_count(pass_c), .fail_count(fail_c),
    .first_fail_valid(ffv_c), .first_fail_idx(ffidx_c)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb, s;
    bb = f[2] ? ~b : b;
    s  = a + bb + {31'd0, f[2]};
    case (f[1:0])
      2'd0:    return a & bb;
      2'd1:    return a | bb;
      2'd2:    return s;
      default: return {31'd0, s[31]};
    endcase
  endfunction

  function automatic tv_vec_t mk(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] y, input logic z);
    tv_vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp_y = y; v.exp_zero = z;
    return v;
  endfunction

  function automatic exp_t model(input tv_vec_t v[$]);
    exp_t e;
    logic [31:0] y;
    e = '{pass_n: 0, fail_n: 0, ffv: 0, ffidx: 0};
    foreach (v[i]) begin
      y = alu_ref(v[i].f[2:0], v[i].a, v[i].b);
      if (y !== v[i].exp_y || (y == 32'd0) !== v[i].exp_zero) begin
        e.fail_n++;
        if (e.ffv == 0) begin e.ffv = 1; e.ffidx = i; end
      end else begin
        e.pass_n++;
      end
    end
    return e;
  endfunction

  // Vector memories and ALUs; C's ALU result lags its operands by two cycles
  logic [31:0] c_p1 = '0, c_p2 = '0;
  always @(posedge clk) begin
    if (ifa.vec_rd_en) ifa.vec_data <= mem_a[ifa.vec_addr];
    if (ifb.vec_rd_en) ifb.vec_data <= mem_b[ifb.vec_addr];
    if (ifc.vec_rd_en) ifc.vec_data <= mem_c[ifc.vec_addr];
    c_p1 <= alu_ref(ifc.alu_f, ifc.alu_a, ifc.alu_b);
    c_p2 <= c_p1;
  end
  assign ifa.alu_y    = alu_ref(ifa.alu_f, ifa.alu_a, ifa.alu_b);
  assign ifa.alu_zero = (ifa.alu_y == 32'd0);
  assign ifb.alu_y    = alu_ref(ifb.alu_f, ifb.alu_a, ifb.alu_b);
  assign ifb.alu_zero = (ifb.alu_y == 32'd0);
  assign ifc.alu_y    = c_p2;
  assign ifc.alu_zero = (c_p2 == 32'd0);

  always @(negedge clk) begin
    if (ifa.vec_rd_en) begin
      checks++;
      if (addr_q_a.size() == 0) begin
        failures++;
        $display("FAIL a_rd_addr: unexpected read at addr %0d, none required", ifa.vec_addr);
      end else begin
        int e;
        e = addr_q_a.pop_front();
        if (ifa.vec_addr !== e[1:0]) begin
          failures++;
          $display("FAIL a_rd_addr: got %0d required %0d", ifa.vec_addr, e);
        end
      end
    end
    if (ifc.vec_rd_en) begin
      checks++;
      if (addr_q_c.size() == 0) begin
        failures++;
        $display("FAIL c_rd_addr: unexpected read at addr %0d, none required", ifc.vec_addr);
      end else begin
        int e;
        e = addr_q_c.pop_front();
        if (ifc.vec_addr !== e[1:0]) begin
          failures++;
          $display("FAIL c_rd_addr: got %0d required %0d", ifc.vec_addr, e);
        end
      end
      if (prev_c >= 0) begin
        checks++;
        if (cyc_cnt - prev_c != 6) begin
          failures++;
          $display("FAIL c_spacing: got %0d cycles required 6", cyc_cnt - prev_c);
        end
      end
      prev_c = cyc_cnt;
    end
  end

  task automatic run_a(input int pulse_at, output int cyc);
    for (int i = 0; i < 4; i++) addr_q_a.push_back(i);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 200) begin
      if (cyc == pulse_at) start_a = 1'b1;
      @(negedge clk); start_a = 1'b0; cyc++;
    end
    checks++;
    if (!done_a) begin
      failures++;
      $display("FAIL a_timeout: done=%0b after %0d cycles, required 1", done_a, cyc);
    end
  endtask

  task automatic check_totals_a(input string name, input int cyc);
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    if (cyc != 16) begin failures++; $display("FAIL %s_cycles: got %0d required 16", name, cyc); end
    checks++;
    if (pass_a !== e.pass_n[2:0] || fail_a !== e.fail_n[2:0]) begin
      failures++;
      $display("FAIL %s_counts: got pass=%0d fail=%0d required pass=%0d fail=%0d", name, pass_a, fail_a, e.pass_n, e.fail_n);
    end
    checks++;
    if (ffv_a !== e.ffv[0] || ffidx_a !== e.ffidx[1:0]) begin
      failures++;
      $display("FAIL %s_first_fail: got v=%0b idx=%0d required v=%0d idx=%0d", name, ffv_a, ffidx_a, e.ffv, e.ffidx);
    end
    checks++;
    if (addr_q_a.size() != 0) begin
      failures++;
      $display("FAIL %s_reads: %0d reads missing, required 0", name, addr_q_a.size());
    end
  endtask

  task automatic load_mixed();
    mem_a.delete();
    mem_a.push_back(mk(4'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0));
    mem_a.push_back(mk(4'h1, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0));
    mem_a.push_back(mk(4'h6, 32'd7, 32'd7, 32'd0, 1'b0));
    mem_a.push_back(mk(4'h7, 32'd3, 32'd9, 32'd1, 1'b0));
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, ifa.vec_rd_en, ffv_a, busy_c, done_c} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000", {busy_a, done_a, ifa.vec_rd_en, ffv_a, busy_c, done_c});
    end
    checks++;
    if ({pass_a, fail_a, ffidx_a, ifa.vec_addr} !== 10'b0) begin
      failures++;
      $display("FAIL reset_counters: got %b required 0", {pass_a, fail_a, ffidx_a, ifa.vec_addr});
    end
    checks++;
    if ({ifa.alu_a, ifa.alu_b, ifa.alu_f} !== 67'b0) begin
      failures++;
      $display("FAIL reset_operands: got a=%h b=%h f=%0d required 0", ifa.alu_a, ifa.alu_b, ifa.alu_f);
    end
  endtask

  task automatic test_single_pass();
    exp_t e;
    int   cyc;
    mem_b.delete();
    mem_b.push_back(mk(4'h2, 32'd5, 32'd3, 32'd8, 1'b0));
    sb_q.push_back(model(mem_b));
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 50) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    checks++;
    if (cyc != 4) begin failures++; $display("FAIL single_latency: got %0d required 4", cyc); end
    checks++;
    if (pass_b !== e.pass_n[0] || fail_b !== e.fail_n[0] || ffv_b !== e.ffv[0]) begin
      failures++;
      $display("FAIL single_counts: got pass=%0d fail=%0d ffv=%0b required %0d %0d %0d", pass_b, fail_b, ffv_b, e.pass_n, e.fail_n, e.ffv);
    end
  endtask

  task automatic test_mixed();
    int cyc;
    load_mixed();
    sb_q.push_back(model(mem_a));
    run_a(-1, cyc);
    check_totals_a("mixed", cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || ifa.alu_f !== 3'd7 || ifa.alu_b !== 32'd9) begin
      failures++;
      $display("FAIL mixed_hold: got done=%0b f=%0d b=%0d required 1 7 9", done_a, ifa.alu_f, ifa.alu_b);
    end
  endtask

  task automatic test_multi_fail();
    int cyc;
    mem_a.delete();
    mem_a.push_back(mk(4'h2, 32'd1, 32'd1, 32'd2, 1'b0));
    mem_a.push_back(mk(4'h1, 32'd1, 32'd2, 32'd4, 1'b0));
    mem_a.push_back(mk(4'h0, 32'd5, 32'd2, 32'd0, 1'b1));
    mem_a.push_back(mk(4'hE, 32'd10, 32'd4, 32'd6, 1'b1));
    sb_q.push_back(model(mem_a));
    run_a(-1, cyc);
    check_totals_a("multi", cyc);
    checks++;
    if (ifa.alu_f !== 3'd6) begin
      failures++;
      $display("FAIL multi_f3_ignored: got alu_f=%0d required 6", ifa.alu_f);
    end
  endtask

  task automatic test_settle();
    exp_t e;
    int   cyc;
    mem_c.delete();
    mem_c.push_back(mk(4'h2, 32'd100, 32'd23, 32'd123, 1'b0));
    mem_c.push_back(mk(4'h6, 32'd50, 32'd50, 32'd0, 1'b1));
    mem_c.push_back(mk(4'h7, 32'd9, 32'd3, 32'd0, 1'b1));
    mem_c.push_back(mk(4'h1, 32'h10, 32'h01, 32'h11, 1'b0));
    sb_q.push_back(model(mem_c));
    for (int i = 0; i < 4; i++) addr_q_c.push_back(i);
    prev_c = -1;
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    cyc = 0;
    while (!done_c && cyc < 200) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    checks++;
    if (cyc != 24) begin failures++; $display("FAIL settle_cycles: got %0d required 24", cyc); end
    checks++;
    if (pass_c !== e.pass_n[2:0] || fail_c !== e.fail_n[2:0] || ffv_c !== e.ffv[0]) begin
      failures++;
      $display("FAIL settle_counts: got pass=%0d fail=%0d ffv=%0b required %0d %0d %0d", pass_c, fail_c, ffv_c, e.pass_n, e.fail_n, e.ffv);
    end
    checks++;
    if (addr_q_c.size() != 0) begin
      failures++;
      $display("FAIL settle_reads: %0d reads missing, required 0", addr_q_c.size());
    end
  endtask

  task automatic test_control();
    int cyc;
    load_mixed();
    sb_q.push_back(model(mem_a));
    run_a(5, cyc);
    check_totals_a("busy_start", cyc);
    sb_q.push_back(model(mem_a));
    run_a(-1, cyc);
    check_totals_a("restart", cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_mixed();
    for (int i = 0; i < 4; i++) addr_q_a.push_back(i);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ifa.vec_addr !== 2'd2 || busy_a !== 1'b1 || pass_a !== 3'd2) begin
      failures++;
      $display("FAIL mid_position: got addr=%0d busy=%0b pass=%0d required 2 1 2", ifa.vec_addr, busy_a, pass_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, ffv_a, pass_a, fail_a, ifa.vec_addr, ifa.alu_a, ifa.alu_b, ifa.alu_f} !== 78'b0) begin
      failures++;
      $display("FAIL mid_async_reset: got busy=%0b pass=%0d a=%h b=%h f=%0d required all 0", busy_a, pass_a, ifa.alu_a, ifa.alu_b, ifa.alu_f);
    end
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    addr_q_a.delete();
    sb_q.push_back(model(mem_a));
    run_a(-1, cyc);
    check_totals_a("after_reset", cyc);
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_mixed();
    test_multi_fail();
    test_settle();
    test_control();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
